// File: rtl/adc_cal_pkg.sv
// Shared types and helpers for the ADC offset-calibration controller.
//   cal_state_t : calibration sequencer states
//   MID_CODE    : mid-scale code of the default 8-bit converter
//   sat_sub_u   : unsigned code minus signed offset, saturated to [0, max_code]
package adc_cal_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    ACCUM   = 3'd2,
    COMPUTE = 3'd3,
    MISSION = 3'd4
  } cal_state_t;

  localparam int unsigned DEF_BITW = 32'd8;
  localparam int unsigned MID_CODE = 32'd1 << (DEF_BITW - 32'd1);

  // Operands are widened by two bits so the difference can never wrap
  // before it is clamped.
  function automatic logic [31:0] sat_sub_u(input logic [31:0]        code,
                                            input logic signed [31:0] ofs,
                                            input logic [31:0]        max_code);
    logic signed [33:0] diff_s;
    logic [31:0]        res_s;
    diff_s = $signed({2'b00, code}) - $signed({{2{ofs[31]}}, ofs});
    if (diff_s < 34'sd0) begin
      res_s = 32'd0;
    end else if (diff_s > $signed({2'b00, max_code})) begin
      res_s = max_code;
    end else begin
      res_s = diff_s[31:0];
    end
    return res_s;
  endfunction

endpackage

// File: rtl/adc_ofs_accum.sv
// Offset estimator: signed accumulator of (sample - mid code), sample counter,
// round-half-up division by 2^LOG2_NAVG and clamp to +/-OFS_MAX.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   clr          clear accumulator and counter (held during settling)
//   smp_en       smp is a calibration sample to accumulate
//   smp          raw ADC code
//   compute      load offset_code / cal_err from the current estimate
//   last_smp     this smp_en is the final sample of the batch
//   offset_code  stored signed offset
//   cal_err      last estimate was clamped
module adc_ofs_accum
  import adc_cal_pkg::*;
#(
  parameter int BITW      = 8,
  parameter int LOG2_NAVG = 4,
  parameter int OFS_W     = 6,
  parameter int OFS_MAX   = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    smp_en,
  input  logic [BITW-1:0]         smp,
  input  logic                    compute,
  output logic                    last_smp,
  output logic signed [OFS_W-1:0] offset_code,
  output logic                    cal_err
);

  localparam int AW = BITW + LOG2_NAVG + 1;
  localparam logic signed [AW-1:0]    MID_AW  = AW'(1) <<< (BITW - 1);
  localparam logic signed [AW-1:0]    HALF_AW = AW'(1) <<< (LOG2_NAVG - 1);
  localparam logic signed [AW-1:0]    OMAX_AW = AW'(OFS_MAX);
  localparam logic signed [OFS_W-1:0] OMAX_O  = OFS_W'(OFS_MAX);

  logic signed [AW-1:0]    acc_r;
  logic [LOG2_NAVG-1:0]    cnt_r;
  logic signed [AW-1:0]    smp_s;
  logic signed [AW-1:0]    est_s;
  logic signed [OFS_W-1:0] ofs_nxt_s;
  logic                    err_nxt_s;
  logic signed [OFS_W-1:0] offset_code_r;
  logic                    cal_err_r;

  assign smp_s    = $signed({{(AW - BITW){1'b0}}, smp}) - MID_AW;
  // Arithmetic shift after adding half an LSB gives floor(x + 0.5).
  assign est_s    = (acc_r + HALF_AW) >>> LOG2_NAVG;
  assign last_smp = smp_en && (cnt_r == {LOG2_NAVG{1'b1}});

  // Clamp the rounded estimate and flag out-of-range results.
  always_comb begin
    ofs_nxt_s = est_s[OFS_W-1:0];
    err_nxt_s = 1'b0;
    if (est_s > OMAX_AW) begin
      ofs_nxt_s = OMAX_O;
      err_nxt_s = 1'b1;
    end else if (est_s < -OMAX_AW) begin
      ofs_nxt_s = -OMAX_O;
      err_nxt_s = 1'b1;
    end else begin
      ofs_nxt_s = est_s[OFS_W-1:0];
      err_nxt_s = 1'b0;
    end
  end

  // Accumulator, sample counter and stored offset/error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r         <= {AW{1'b0}};
      cnt_r         <= {LOG2_NAVG{1'b0}};
      offset_code_r <= {OFS_W{1'b0}};
      cal_err_r     <= 1'b0;
    end else begin
      if (clr) begin
        acc_r <= {AW{1'b0}};
        cnt_r <= {LOG2_NAVG{1'b0}};
      end else if (smp_en) begin
        acc_r <= acc_r + smp_s;
        cnt_r <= cnt_r + LOG2_NAVG'(1);
      end
      if (compute) begin
        offset_code_r <= ofs_nxt_s;
        cal_err_r     <= err_nxt_s;
      end
    end
  end

  assign offset_code = offset_code_r;
  assign cal_err     = cal_err_r;

endmodule

// File: rtl/adc_ofs_cal_ctrl.sv
// ADC offset-calibration sequencer and mission-mode output corrector.
// Ports:
//   clk, rst     ADC sample clock, synchronous active-high reset
//   start        1-cycle calibration request (ignored while busy)
//   adc_valid    adc_dout carries a new sample
//   adc_dout     raw ADC code
//   cal_short    short ADC input to common mode (SETTLE/ACCUM)
//   busy         calibration in progress
//   cal_done     1-cycle pulse when calibration finishes
//   cal_err      sticky: last estimate was clamped
//   offset_code  signed stored offset
//   dout_valid   dout_corr valid (one cycle after adc_valid in mission)
//   dout_corr    offset-corrected, saturated code
module adc_ofs_cal_ctrl
  import adc_cal_pkg::*;
#(
  parameter int BITW       = 8,
  parameter int LOG2_NAVG  = 4,
  parameter int SETTLE_CYC = 8,
  parameter int OFS_W      = 6,
  parameter int OFS_MAX    = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    adc_valid,
  input  logic [BITW-1:0]         adc_dout,
  output logic                    cal_short,
  output logic                    busy,
  output logic                    cal_done,
  output logic                    cal_err,
  output logic signed [OFS_W-1:0] offset_code,
  output logic                    dout_valid,
  output logic [BITW-1:0]         dout_corr
);

  localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYC - 1);
  localparam logic [31:0]    MAX_CODE    = 32'((64'd1 << BITW) - 64'd1);

  cal_state_t      state_r, state_nxt_s;
  logic [SCW-1:0]  settle_cnt_r;
  logic            last_smp_s;
  logic            cal_short_r, busy_r, cal_done_r, dout_valid_r;
  logic [BITW-1:0] dout_corr_r;
  logic            cal_short_nxt_s, busy_nxt_s, cal_done_nxt_s, dout_valid_nxt_s;
  logic [BITW-1:0] dout_corr_nxt_s;

  adc_ofs_accum #(
    .BITW      (BITW),
    .LOG2_NAVG (LOG2_NAVG),
    .OFS_W     (OFS_W),
    .OFS_MAX   (OFS_MAX)
  ) u_accum (
    .clk         (clk),
    .rst         (rst),
    .clr         (state_r == SETTLE),
    .smp_en      ((state_r == ACCUM) && adc_valid),
    .smp         (adc_dout),
    .compute     (state_r == COMPUTE),
    .last_smp    (last_smp_s),
    .offset_code (offset_code),
    .cal_err     (cal_err)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Settle counter: counts cycles spent in SETTLE, zero elsewhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt_r <= {SCW{1'b0}};
    end else if (state_r == SETTLE) begin
      settle_cnt_r <= settle_cnt_r + SCW'(1);
    end else begin
      settle_cnt_r <= {SCW{1'b0}};
    end
  end

  // Next-state logic; start is only honoured from IDLE and MISSION.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = start ? SETTLE : IDLE;
      SETTLE:  state_nxt_s = (settle_cnt_r == SETTLE_LAST) ? ACCUM : SETTLE;
      ACCUM:   state_nxt_s = last_smp_s ? COMPUTE : ACCUM;
      COMPUTE: state_nxt_s = MISSION;
      MISSION: state_nxt_s = start ? SETTLE : MISSION;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output next values; status flags follow the state being entered so the
  // registered outputs line up with the state register.
  always_comb begin
    cal_short_nxt_s  = (state_nxt_s == SETTLE) || (state_nxt_s == ACCUM);
    busy_nxt_s       = (state_nxt_s == SETTLE) || (state_nxt_s == ACCUM) ||
                       (state_nxt_s == COMPUTE);
    cal_done_nxt_s   = (state_r == COMPUTE);
    dout_valid_nxt_s = (state_r == MISSION) && adc_valid && !start;
    if (dout_valid_nxt_s) begin
      dout_corr_nxt_s = BITW'(sat_sub_u(32'(adc_dout), 32'(offset_code), MAX_CODE));
    end else begin
      dout_corr_nxt_s = dout_corr_r;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cal_short_r  <= 1'b0;
      busy_r       <= 1'b0;
      cal_done_r   <= 1'b0;
      dout_valid_r <= 1'b0;
      dout_corr_r  <= {BITW{1'b0}};
    end else begin
      cal_short_r  <= cal_short_nxt_s;
      busy_r       <= busy_nxt_s;
      cal_done_r   <= cal_done_nxt_s;
      dout_valid_r <= dout_valid_nxt_s;
      dout_corr_r  <= dout_corr_nxt_s;
    end
  end

  assign cal_short  = cal_short_r;
  assign busy       = busy_r;
  assign cal_done   = cal_done_r;
  assign dout_valid = dout_valid_r;
  assign dout_corr  = dout_corr_r;

endmodule
